vga_timing_gen: RTL and testbench

Parametrised raster timing generator; successor to the fixed 640x480 sync generator. It produces horizontal/vertical sync, data-enable, blanking and pixel coordinates for any mode set by parameters. Pixel rate comes from a configurable clock-enable divider. It adds frame/line strobes, a run/freeze control, and a look-ahead fetch coordinate so framebuffer reads can be issued ahead of display. It sits between the system clock and the pixel pipeline and drives the VGA connector's sync pins.

---
 rtl/vga_timing_if.sv | 33 +++
 rtl/vga_timing_gen.sv | 185 ++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_if.sv
// Raster timing bundle between the timing generator and the pixel pipeline.
interface vga_timing_if #(
   parameter int unsigned CW = 10
);
   logic          enable;
   logic          pix_en;
   logic          h_sync;
   logic          v_sync;
   logic          de;
   logic          hblank;
   logic          vblank;
   logic [CW-1:0] xpos;
   logic [CW-1:0] ypos;
   logic          line_start;
   logic          frame_start;
   logic [CW-1:0] fetch_x;
   logic [CW-1:0] fetch_y;
   logic          fetch_valid;

   // Timing generator side: takes the run control, drives the raster.
   modport master (
      input  enable,
      output pix_en, h_sync, v_sync, de, hblank, vblank, xpos, ypos,
             line_start, frame_start, fetch_x, fetch_y, fetch_valid
   );

   // Pixel pipeline side.
   modport slave (
      output enable,
      input  pix_en, h_sync, v_sync, de, hblank, vblank, xpos, ypos,
             line_start, frame_start, fetch_x, fetch_y, fetch_valid
   );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel clock-enable divider, h/v
// raster counters, a look-ahead fetch counter pair and registered region
// decode for sync, data-enable, blanking and coordinates.
module vga_timing_gen #(
   parameter int unsigned H_ACTIVE  = 640,
   parameter int unsigned H_FP      = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BP      = 48,
   parameter int unsigned V_ACTIVE  = 480,
   parameter int unsigned V_FP      = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BP      = 33,
   parameter bit          HS_POL    = 1'b0,
   parameter bit          VS_POL    = 1'b0,
   parameter int unsigned CLK_DIV   = 2,
   parameter int unsigned LOOKAHEAD = 0,
   parameter int unsigned CW        = 10
) (
   input logic          clk,
   input logic          reset,
   vga_timing_if.master vif
);

   localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
   localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
   localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
   localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;
   localparam int unsigned DW           = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] LA_INIT  = CW'(LOOKAHEAD);
   localparam bit            LA_VALID = (LOOKAHEAD < H_ACTIVE);

   // Divider and raster counters
   logic [DW-1:0] div_q, div_d;
   logic [CW-1:0] h_q, h_d;
   logic [CW-1:0] v_q, v_d;
   logic [CW-1:0] fh_q, fh_d;
   logic [CW-1:0] fv_q, fv_d;

   // Registered level outputs
   logic          h_sync_q, h_sync_d;
   logic          v_sync_q, v_sync_d;
   logic          de_q, de_d;
   logic          hblank_q, hblank_d;
   logic          vblank_q, vblank_d;
   logic [CW-1:0] xpos_q, xpos_d;
   logic [CW-1:0] ypos_q, ypos_d;
   logic [CW-1:0] fetch_x_q, fetch_x_d;
   logic [CW-1:0] fetch_y_q, fetch_y_d;
   logic          fetch_valid_q, fetch_valid_d;

   // Strobes are combinational so they line up with the edge that moves the counters
   logic          pix_en_c;
   logic          line_start_c;
   logic          frame_start_c;

   // Pixel strobe and line/frame markers for the current counter position
   always_comb begin
      pix_en_c      = vif.enable && !reset && (div_q == DIV_LAST);
      line_start_c  = pix_en_c && (h_q == '0);
      frame_start_c = line_start_c && (v_q == '0);
   end

   // Next divider and counter values; the fetch pair wraps exactly like (h,v)
   always_comb begin
      div_d = div_q;
      h_d   = h_q;
      v_d   = v_q;
      fh_d  = fh_q;
      fv_d  = fv_q;

      if (vif.enable) begin
         div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
      end

      if (pix_en_c) begin
         if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + CW'(1);
         end else begin
            h_d = h_q + CW'(1);
         end

         if (fh_q == H_LAST) begin
            fh_d = '0;
            fv_d = (fv_q == V_LAST) ? '0 : fv_q + CW'(1);
         end else begin
            fh_d = fh_q + CW'(1);
         end
      end
   end

   // Region decode of the next counter values so outputs move with the counters
   always_comb begin
      hblank_d      = 1'b0;
      vblank_d      = 1'b0;
      de_d          = 1'b0;
      h_sync_d      = ~HS_POL;
      v_sync_d      = ~VS_POL;
      xpos_d        = '0;
      ypos_d        = '0;
      fetch_valid_d = 1'b0;
      fetch_x_d     = '0;
      fetch_y_d     = '0;

      hblank_d = (32'(h_d) >= H_ACTIVE);
      vblank_d = (32'(v_d) >= V_ACTIVE);
      de_d     = !hblank_d && !vblank_d;

      if ((32'(h_d) >= H_SYNC_START) && (32'(h_d) < H_SYNC_END)) begin
         h_sync_d = HS_POL;
      end
      if ((32'(v_d) >= V_SYNC_START) && (32'(v_d) < V_SYNC_END)) begin
         v_sync_d = VS_POL;
      end

      if (de_d) begin
         xpos_d = h_d;
         ypos_d = v_d;
      end

      fetch_valid_d = (32'(fh_d) < H_ACTIVE) && (32'(fv_d) < V_ACTIVE);
      if (fetch_valid_d) begin
         fetch_x_d = fh_d;
         fetch_y_d = fv_d;
      end
   end

   // State and output registers; reset returns to top-left with fetch LOOKAHEAD ahead
   always_ff @(posedge clk) begin
      if (reset) begin
         div_q         <= '0;
         h_q           <= '0;
         v_q           <= '0;
         fh_q          <= LA_INIT;
         fv_q          <= '0;
         h_sync_q      <= ~HS_POL;
         v_sync_q      <= ~VS_POL;
         de_q          <= 1'b1;
         hblank_q      <= 1'b0;
         vblank_q      <= 1'b0;
         xpos_q        <= '0;
         ypos_q        <= '0;
         fetch_valid_q <= LA_VALID;
         fetch_x_q     <= LA_VALID ? LA_INIT : '0;
         fetch_y_q     <= '0;
      end else begin
         div_q         <= div_d;
         h_q           <= h_d;
         v_q           <= v_d;
         fh_q          <= fh_d;
         fv_q          <= fv_d;
         h_sync_q      <= h_sync_d;
         v_sync_q      <= v_sync_d;
         de_q          <= de_d;
         hblank_q      <= hblank_d;
         vblank_q      <= vblank_d;
         xpos_q        <= xpos_d;
         ypos_q        <= ypos_d;
         fetch_valid_q <= fetch_valid_d;
         fetch_x_q     <= fetch_x_d;
         fetch_y_q     <= fetch_y_d;
      end
   end

   assign vif.pix_en      = pix_en_c;
   assign vif.line_start  = line_start_c;
   assign vif.frame_start = frame_start_c;
   assign vif.h_sync      = h_sync_q;
   assign vif.v_sync      = v_sync_q;
   assign vif.de          = de_q;
   assign vif.hblank      = hblank_q;
   assign vif.vblank      = vblank_q;
   assign vif.xpos        = xpos_q;
   assign vif.ypos        = ypos_q;
   assign vif.fetch_x     = fetch_x_q;
   assign vif.fetch_y     = fetch_y_q;
   assign vif.fetch_valid = fetch_valid_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen in a 16x8 raster mode with a 2-clk pixel and
// a 3-pixel fetch lead. A linear pixel-index model feeds a scoreboard.
module tb_vga_timing_gen;

   localparam int unsigned CW      = 10;
   localparam int          HT      = 16;
   localparam int          VT      = 8;
   localparam int          PF      = HT * VT;
   localparam int          CLK_DIV = 2;
   localparam int          LA      = 3;

   typedef struct packed {
      logic          de;
      logic          hblank;
      logic          vblank;
      logic          hs;
      logic          vs;
      logic          fvalid;
      logic [CW-1:0] xpos;
      logic [CW-1:0] ypos;
      logic [CW-1:0] fx;
      logic [CW-1:0] fy;
   } lv_t;

   typedef struct packed {
      logic pix;
      logic ls;
      logic fs;
      lv_t  lv;
   } exp_t;

   typedef struct {
      string name;
      logic  r;
      logic  e;
      int    ncyc;
      lv_t   exp;
   } row_t;

   logic clk = 1'b0;
   logic reset;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   m_div = 0;
   int   m_p   = 0;
   logic s_pix, s_ls, s_fs;
   exp_t sb_q[$];
   row_t rows[8];

   vga_timing_if #(.CW(CW)) vif ();

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HS_POL(1'b0), .VS_POL(1'b0),
      .CLK_DIV(CLK_DIV), .LOOKAHEAD(LA), .CW(CW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .vif   (vif)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1, "watchdog");
   end

   function automatic lv_t mk_lv(input int de, hb, vb, hs, vs, fv, x, y, fx, fy);
      lv_t l;
      l.de = 1'(de); l.hblank = 1'(hb); l.vblank = 1'(vb);
      l.hs = 1'(hs); l.vs = 1'(vs); l.fvalid = 1'(fv);
      l.xpos = CW'(x); l.ypos = CW'(y); l.fx = CW'(fx); l.fy = CW'(fy);
      return l;
   endfunction

   // Expected outputs from the pixel index: h = p mod 16, v = p div 16
   function automatic exp_t model_exp(input logic r, input logic e);
      exp_t x;
      int   h, v, fp, fh, fv;
      h  = m_p % HT;
      v  = m_p / HT;
      fp = (m_p + LA) % PF;
      fh = fp % HT;
      fv = fp / HT;
      x.pix       = !r && e && (m_div == CLK_DIV - 1);
      x.ls        = x.pix && (h == 0);
      x.fs        = x.ls && (v == 0);
      x.lv.de     = (h < 8) && (v < 4);
      x.lv.hblank = (h >= 8);
      x.lv.vblank = (v >= 4);
      x.lv.hs     = !((h >= 10) && (h <= 12));
      x.lv.vs     = !((v >= 5) && (v <= 6));
      x.lv.xpos   = x.lv.de ? CW'(h) : '0;
      x.lv.ypos   = x.lv.de ? CW'(v) : '0;
      x.lv.fvalid = (fh < 8) && (fv < 4);
      x.lv.fx     = x.lv.fvalid ? CW'(fh) : '0;
      x.lv.fy     = x.lv.fvalid ? CW'(fv) : '0;
      return x;
   endfunction

   function automatic lv_t sample_lv();
      lv_t l;
      l.de = vif.de; l.hblank = vif.hblank; l.vblank = vif.vblank;
      l.hs = vif.h_sync; l.vs = vif.v_sync; l.fvalid = vif.fetch_valid;
      l.xpos = vif.xpos; l.ypos = vif.ypos; l.fx = vif.fetch_x; l.fy = vif.fetch_y;
      return l;
   endfunction

   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h (p=%0d div=%0d t=%0t)", name, act, exp, m_p, m_div, $time);
      end
   endtask

   task automatic model_tick(input logic r, input logic e);
      if (r) begin
         m_div = 0;
         m_p   = 0;
      end else if (e) begin
         if (m_div == CLK_DIV - 1) begin
            m_div = 0;
            m_p   = (m_p + 1) % PF;
         end else begin
            m_div++;
         end
      end
   endtask

   // One clk: drive, score the pre-edge outputs, advance model on the edge
   task automatic step(input logic r, input logic e);
      exp_t x, got;
      reset      = r;
      vif.enable = e;
      #1;
      sb_q.push_back(model_exp(r, e));
      got.pix = vif.pix_en;
      got.ls  = vif.line_start;
      got.fs  = vif.frame_start;
      got.lv  = sample_lv();
      x = sb_q.pop_front();
      cmp("cycle", 64'(got), 64'(x));
      s_pix = got.pix;
      s_ls  = got.ls;
      s_fs  = got.fs;
      @(posedge clk);
      model_tick(r, e);
      @(negedge clk);
   endtask

   task automatic lv_check(input string name, input lv_t exp);
      #1;
      cmp(name, 64'(sample_lv()), 64'(exp));
   endtask

   task automatic run_to(input int p, input int d, input string name);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if (m_p == p && m_div == d) begin
            hit = 1'b1;
            break;
         end
         step(1'b0, 1'b1);
      end
      cmp(name, 64'(hit), 64'(1));
   endtask

   initial begin
      int fr[$];
      int ln[$];
      bit found;

      rows[0] = '{name:"row_reset",  r:1'b1, e:1'b1, ncyc:3,   exp:mk_lv(1,0,0,1,1,1, 0,0,3,0)};
      rows[1] = '{name:"row_h4",     r:1'b0, e:1'b1, ncyc:8,   exp:mk_lv(1,0,0,1,1,1, 4,0,7,0)};
      rows[2] = '{name:"row_hsync",  r:1'b0, e:1'b1, ncyc:14,  exp:mk_lv(0,1,0,0,1,0, 0,0,0,0)};
      rows[3] = '{name:"row_line1",  r:1'b0, e:1'b1, ncyc:12,  exp:mk_lv(1,0,0,1,1,1, 1,1,4,1)};
      rows[4] = '{name:"row_freeze", r:1'b0, e:1'b0, ncyc:6,   exp:mk_lv(1,0,0,1,1,1, 1,1,4,1)};
      rows[5] = '{name:"row_vblank", r:1'b0, e:1'b1, ncyc:116, exp:mk_lv(0,1,1,0,1,0, 0,0,0,0)};
      rows[6] = '{name:"row_vsync",  r:1'b0, e:1'b1, ncyc:20,  exp:mk_lv(0,0,1,1,0,0, 0,0,0,0)};
      rows[7] = '{name:"row_wrap",   r:1'b0, e:1'b1, ncyc:86,  exp:mk_lv(1,0,0,1,1,1, 0,0,3,0)};

      reset      = 1'b1;
      vif.enable = 1'b1;
      @(negedge clk);
      repeat (2) @(negedge clk);
      m_div = 0;
      m_p   = 0;

      // Table of stimulus segments with hand-derived end-of-segment levels
      foreach (rows[k]) begin
         for (int c = 0; c < rows[k].ncyc; c++) step(rows[k].r, rows[k].e);
         lv_check(rows[k].name, rows[k].exp);
      end

      // Strobe periods over 600 clks from reset
      step(1'b1, 1'b1);
      for (int i = 0; i < 600; i++) begin
         step(1'b0, 1'b1);
         if (s_fs) fr.push_back(i + 1);
         if (s_ls) ln.push_back(i + 1);
      end
      cmp("frame_count", 64'(fr.size()), 64'(3));
      if (fr.size() > 0) cmp("first_frame_clk", 64'(fr[0]), 64'(2));
      for (int i = 1; i < fr.size(); i++) cmp("frame_period", 64'(fr[i] - fr[i-1]), 64'(256));
      cmp("line_count", 64'(ln.size()), 64'(19));
      begin
         int bad_lines;
         bad_lines = 0;
         for (int i = 1; i < ln.size(); i++) if (ln[i] - ln[i-1] != 32) bad_lines++;
         cmp("line_period", 64'(bad_lines), 64'(0));
      end

      // Look-ahead wraps across the frame end: (13,7) fetches (0,0)
      run_to(125, 0, "reach_h13_v7");
      #1;
      cmp("fetch_wrap_x", 64'(vif.fetch_x), 64'(0));
      cmp("fetch_wrap_y", 64'(vif.fetch_y), 64'(0));
      cmp("fetch_wrap_valid", 64'(vif.fetch_valid), 64'(1));
      repeat (6) step(1'b0, 1'b1);
      lv_check("frame_wrap", mk_lv(1,0,0,1,1,1, 0,0,3,0));

      // Freeze mid-line at h=4 for 5 clks, then resume at h=5
      run_to(36, 0, "reach_h4_v2");
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b0);
         cmp("freeze_pix_en", 64'(s_pix), 64'(0));
         lv_check("freeze_levels", mk_lv(1,0,0,1,1,1, 4,2,7,2));
      end
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      cmp("resume_strobe", 64'(s_pix), 64'(1));
      lv_check("resume_h5", mk_lv(1,0,0,1,1,0, 5,2,0,0));

      // Reset mid-frame at v=2, h=9 with the divider mid-count
      run_to(41, 1, "reach_h9_v2");
      step(1'b1, 1'b1);
      lv_check("mid_reset_state", mk_lv(1,0,0,1,1,1, 0,0,3,0));
      found = 1'b0;
      for (int i = 0; i < 4 && !found; i++) begin
         step(1'b0, 1'b1);
         if (s_pix) begin
            found = 1'b1;
            cmp("first_strobe_fs", 64'(s_fs), 64'(1));
            cmp("first_strobe_clk", 64'(i + 1), 64'(2));
         end
      end
      cmp("strobe_after_reset", 64'(found), 64'(1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
